seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider.sv | 163 ++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider for the MIPS divide unit: one trial subtraction per clock.
// Optional macro DIVIDER_SIGNED_EN selects two's-complement operands (default: unsigned).
module seq_restoring_divider #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH+1:0] ONE_T     = {{(WIDTH+1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_shifted;
    logic [WIDTH-1:0] q_shifted;
    logic [WIDTH+1:0] trial;
    logic             no_borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    // Subtraction done as R + ~{0,D} + 1; the carry out of the top bit means no borrow.
    assign r_shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign q_shifted = {q_q[WIDTH-2:0], 1'b0};
    assign trial     = {1'b0, r_shifted} + {1'b0, ~{1'b0, d_q}} + ONE_T;
    assign no_borrow = trial[WIDTH+1];
    assign r_next    = no_borrow ? trial[WIDTH:0] : r_shifted;
    assign q_next    = {q_shifted[WIDTH-1:1], no_borrow};

`ifdef DIVIDER_SIGNED_EN
    logic quot_neg_q, quot_neg_d;
    logic rem_neg_q, rem_neg_d;

    assign dividend_mag = Dividend[WIDTH-1] ? (~Dividend + ONE_W) : Dividend;
    assign divisor_mag  = Divisor[WIDTH-1]  ? (~Divisor + ONE_W)  : Divisor;
    assign quot_final   = quot_neg_q ? (~q_next + ONE_W) : q_next;
    assign rem_final    = rem_neg_q ? (~r_next[WIDTH-1:0] + ONE_W) : r_next[WIDTH-1:0];
`else
    assign dividend_mag = Dividend;
    assign divisor_mag  = Divisor;
    assign quot_final   = q_next;
    assign rem_final    = r_next[WIDTH-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        quot_neg_d  = quot_neg_q;
        rem_neg_d   = rem_neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    q_d   = dividend_mag;
                    d_d   = divisor_mag;
                    r_d   = '0;
                    cnt_d = CNT_START;
                    dbz_d = (Divisor == '0);
`ifdef DIVIDER_SIGNED_EN
                    quot_neg_d = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                    rem_neg_d  = Dividend[WIDTH-1];
`endif
                    // Division by zero skips the iterations and reports immediately.
                    if (Divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = Dividend;
                        state_d     = FIN;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    quotient_d  = quot_final;
                    remainder_d = rem_final;
                    state_d     = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            quot_neg_q  <= 1'b0;
            rem_neg_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            quot_neg_q  <= quot_neg_d;
            rem_neg_q   <= rem_neg_d;
`endif
        end
    end

    assign Quotient  = quotient_q;
    assign Remainder = remainder_q;
    assign Busy      = (state_q == RUN);
    assign Done      = (state_q == FIN);
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed-vector bench for seq_restoring_divider at WIDTH=3 (unsigned or DIVIDER_SIGNED_EN).
module tb_seq_restoring_divider;
    localparam int WIDTH = 3;

`ifdef DIVIDER_SIGNED_EN
    localparam logic [2:0] E72Q = 3'd0, E72R = 3'd7;
    localparam logic [2:0] E63Q = 3'd0, E63R = 3'd6;
    localparam logic [2:0] X1Q  = 3'd7, X1R  = 3'd7;
    localparam logic [2:0] X2Q  = 3'd4, X2R  = 3'd0;
`else
    localparam logic [2:0] E72Q = 3'd3, E72R = 3'd1;
    localparam logic [2:0] E63Q = 3'd2, E63R = 3'd0;
    localparam logic [2:0] X1Q  = 3'd2, X1R  = 3'd1;
    localparam logic [2:0] X2Q  = 3'd0, X2R  = 3'd4;
`endif

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       Start;
    logic [2:0] Dividend;
    logic [2:0] Divisor;
    logic [2:0] Quotient;
    logic [2:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivByZero;

    int totalChecks = 0;
    int badChecks   = 0;
    int doneCount;

    seq_restoring_divider #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .CLK(CLK), .RSTn(RSTn), .Start(Start),
        .Dividend(Dividend), .Divisor(Divisor),
        .Quotient(Quotient), .Remainder(Remainder),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Called at a falling edge; drives one request and follows it to its Done cycle.
    task automatic applyStimulus(input logic [2:0] dvd, input logic [2:0] dvs,
                                 input logic [2:0] eq, input logic [2:0] er, input logic edbz,
                                 input bit hold, input bit glitch);
        int doneCycle;
        doneCycle = (dvs == 3'd0) ? 1 : WIDTH + 1;
        Start    = 1'b1;
        Dividend = dvd;
        Divisor  = dvs;
        for (int c = 1; c <= doneCycle; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                Dividend = ~dvd;
                Divisor  = dvs + 3'd1;
                if (!hold) Start = 1'b0;
            end
            if (glitch && c == 2) begin
                Start    = 1'b1;
                Dividend = 3'd1;
                Divisor  = 3'd1;
            end
            if (glitch && c == 3) Start = 1'b0;
            if (c < doneCycle) begin
                checkOutput("busy_during_run", Busy, 1);
                checkOutput("done_early", Done, 0);
            end else begin
                checkOutput("done_pulse", Done, 1);
                checkOutput("busy_at_done", Busy, 0);
                checkOutput("quotient", Quotient, eq);
                checkOutput("remainder", Remainder, er);
                checkOutput("div_by_zero", DivByZero, edbz);
            end
        end
        if (!hold) begin
            @(negedge CLK);
            checkOutput("done_one_cycle", Done, 0);
            checkOutput("busy_after_done", Busy, 0);
            checkOutput("quotient_held", Quotient, eq);
        end
    endtask

    initial begin
        RSTn     = 1'b0;
        Start    = 1'b0;
        Dividend = 3'd0;
        Divisor  = 3'd0;
        repeat (2) @(negedge CLK);
        checkOutput("reset_quotient", Quotient, 0);
        checkOutput("reset_remainder", Remainder, 0);
        checkOutput("reset_busy", Busy, 0);
        checkOutput("reset_done", Done, 0);
        checkOutput("reset_dbz", DivByZero, 0);
        RSTn = 1'b1;
        @(negedge CLK);

        applyStimulus(3'd7, 3'd2, E72Q, E72R, 1'b0, 1'b0, 1'b0);

        applyStimulus(3'd2, 3'd5, 3'd0, 3'd2, 1'b0, 1'b1, 1'b0);
        Dividend = 3'd6;
        Divisor  = 3'd3;
        @(negedge CLK);
        checkOutput("b2b_gap_busy", Busy, 0);
        checkOutput("b2b_gap_done", Done, 0);
        applyStimulus(3'd6, 3'd3, E63Q, E63R, 1'b0, 1'b0, 1'b0);

        applyStimulus(3'd5, 3'd0, 3'd7, 3'd5, 1'b1, 1'b0, 1'b0);

        applyStimulus(3'd7, 3'd2, E72Q, E72R, 1'b0, 1'b0, 1'b1);
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (Done) doneCount++;
        end
        checkOutput("ignored_start_no_extra_done", doneCount, 0);

        Start    = 1'b1;
        Dividend = 3'd7;
        Divisor  = 3'd2;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        checkOutput("pre_reset_busy", Busy, 1);
        RSTn = 1'b0;
        #1;
        checkOutput("midrun_reset_quotient", Quotient, 0);
        checkOutput("midrun_reset_remainder", Remainder, 0);
        checkOutput("midrun_reset_busy", Busy, 0);
        checkOutput("midrun_reset_done", Done, 0);
        checkOutput("midrun_reset_dbz", DivByZero, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (Done || Busy) doneCount++;
        end
        checkOutput("no_done_after_reset", doneCount, 0);
        applyStimulus(3'd7, 3'd2, E72Q, E72R, 1'b0, 1'b0, 1'b0);

        applyStimulus(3'b101, 3'b010, X1Q, X1R, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b100, 3'b111, X2Q, X2R, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
